muxes_tx: RTL and testbench

Transmit-side 4-to-1 byte multiplexer for the physical layer. Samples four parallel byte lanes once per frame and serializes them onto one byte stream at four times the lane rate, lane 0 first. It is the TX counterpart of the RX lane demultiplexers and produces the `data_000`/`valid_000` stream those demultiplexers consume. Runs entirely on `clk_4f`. The lane rate is derived from an internal 2-bit phase counter, not from a separate clock.

---
 rtl/muxes_tx_pkg.sv | 19 +
 rtl/muxes_tx_if.sv | 30 +++
 rtl/muxes_tx_frame_phase_ctr.sv | 42 ++++
 rtl/muxes_tx.sv | 62 ++++++
 tb/tb_muxes_tx.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/muxes_tx_pkg.sv
// Shared constants and types for the muxes_tx 4:1 TX byte serializer.
// MUXES_TX_IDLE_COM_EN selects COM (8'hBC) as the idle symbol instead of 8'h00.
package muxes_tx_pkg;

   localparam int LANES   = 4;
   localparam int PHASE_W = 2;

   typedef logic [PHASE_W-1:0] phase_t;

   // The lanes are sampled on the edge that closes this phase.
   localparam phase_t SAMPLE_PHASE = 2'd3;

`ifdef MUXES_TX_IDLE_COM_EN
   localparam logic [7:0] IDLE_SYM = 8'hBC;
`else
   localparam logic [7:0] IDLE_SYM = 8'h00;
`endif

endpackage

// File: rtl/muxes_tx_if.sv
// Lane inputs and serialized output stream of muxes_tx.
// Handshake: no valid/ready; lanes must be stable on the edge where load_req is high, stream never stalls.
interface muxes_tx_if #(parameter int DATA_W = 8);

   logic [DATA_W-1:0] data_0;
   logic [DATA_W-1:0] data_1;
   logic [DATA_W-1:0] data_2;
   logic [DATA_W-1:0] data_3;
   logic              valid_0;
   logic              valid_1;
   logic              valid_2;
   logic              valid_3;
   logic              load_req;
   logic [DATA_W-1:0] data_000;
   logic              valid_000;
   logic              frame_out;

   modport master (
      output data_0, data_1, data_2, data_3,
      output valid_0, valid_1, valid_2, valid_3,
      input  load_req, data_000, valid_000, frame_out
   );

   modport slave (
      input  data_0, data_1, data_2, data_3,
      input  valid_0, valid_1, valid_2, valid_3,
      output load_req, data_000, valid_000, frame_out
   );

endinterface

// File: rtl/muxes_tx_frame_phase_ctr.sv
// Free-running 2-bit frame phase counter for muxes_tx: produces phase, sample_edge,
// load_req and a flag that is set once the first frame has been sampled.
module frame_phase_ctr
   import muxes_tx_pkg::*;
(
   input  logic   clk_4f,
   input  logic   reset_L,
   output phase_t phase,
   output logic   sample_edge,
   output logic   load_req,
   output logic   primed
);

   phase_t phase_q;
   phase_t phase_d;
   logic   primed_q;
   logic   primed_d;

   always_ff @(posedge clk_4f or negedge reset_L) begin
      if (!reset_L) begin
         phase_q  <= '0;
         primed_q <= 1'b0;
      end else begin
         phase_q  <= phase_d;
         primed_q <= primed_d;
      end
   end

   // Natural 2-bit wrap gives the 3 -> 0 transition.
   always_comb begin
      phase_d  = phase_q + 2'd1;
      primed_d = primed_q | (phase_q == SAMPLE_PHASE);
   end

   always_comb begin
      phase       = phase_q;
      primed      = primed_q;
      sample_edge = (phase_q == SAMPLE_PHASE);
      load_req    = sample_edge & reset_L;
   end

endmodule

// File: rtl/muxes_tx.sv
// Top of the TX 4:1 byte serializer: lane 0 bypasses into the output register at the
// sample edge, lanes 1..3 wait in hold registers. Idle symbol set by MUXES_TX_IDLE_COM_EN.
module muxes_tx
   import muxes_tx_pkg::phase_t, muxes_tx_pkg::IDLE_SYM;
#(
   parameter int DATA_W = 8,
   parameter int LANES  = 4
) (
   input  logic        clk_4f,
   input  logic        reset_L,
   muxes_tx_if.slave   bus,
   output phase_t      dbg_phase,
   output logic        dbg_primed
);

   localparam logic [DATA_W-1:0] IDLE = DATA_W'(IDLE_SYM);

   phase_t            phase;
   phase_t            next_lane;
   logic              sample_edge;
   logic [DATA_W-1:0] hold_data  [1:LANES-1];
   logic              hold_valid [1:LANES-1];

   frame_phase_ctr u_ctr (
      .clk_4f      (clk_4f),
      .reset_L     (reset_L),
      .phase       (phase),
      .sample_edge (sample_edge),
      .load_req    (bus.load_req),
      .primed      (dbg_primed)
   );

   assign dbg_phase = phase;
   assign next_lane = phase + 2'd1;

   // Invalid lanes are replaced by the idle symbol at capture time.
   always_ff @(posedge clk_4f or negedge reset_L) begin
      if (!reset_L) begin
         hold_data     <= '{default: IDLE};
         hold_valid    <= '{default: 1'b0};
         bus.data_000  <= IDLE;
         bus.valid_000 <= 1'b0;
         bus.frame_out <= 1'b0;
      end else begin
         bus.frame_out <= sample_edge;
         if (sample_edge) begin
            bus.data_000  <= bus.valid_0 ? bus.data_0 : IDLE;
            bus.valid_000 <= bus.valid_0;
            hold_data[1]  <= bus.valid_1 ? bus.data_1 : IDLE;
            hold_data[2]  <= bus.valid_2 ? bus.data_2 : IDLE;
            hold_data[3]  <= bus.valid_3 ? bus.data_3 : IDLE;
            hold_valid[1] <= bus.valid_1;
            hold_valid[2] <= bus.valid_2;
            hold_valid[3] <= bus.valid_3;
         end else begin
            bus.data_000  <= hold_data[next_lane];
            bus.valid_000 <= hold_valid[next_lane];
         end
      end
   end

endmodule

// File: tb/tb_muxes_tx.sv
// Randomized bench for muxes_tx: a queue-based stream model predicts every output byte
// from the lane values present at each fourth edge after reset release.
module tb_muxes_tx;

   localparam int DW = 8;
   localparam int W  = DW + 1;
`ifdef MUXES_TX_IDLE_COM_EN
   localparam logic [DW-1:0] IDLE = 8'hBC;
`else
   localparam logic [DW-1:0] IDLE = 8'h00;
`endif

   logic       clk_4f  = 1'b0;
   logic       reset_L = 1'b0;
   logic [1:0] dbg_phase;
   logic       dbg_primed;

   always #5 clk_4f = ~clk_4f;

   muxes_tx_if #(.DATA_W(DW)) bus ();

   muxes_tx #(.DATA_W(DW), .LANES(4)) dut (
      .clk_4f     (clk_4f),
      .reset_L    (reset_L),
      .bus        (bus.slave),
      .dbg_phase  (dbg_phase),
      .dbg_primed (dbg_primed)
   );

   logic [W-1:0]  exp_q[$];
   logic [DW-1:0] lane_d [4];
   logic          lane_v [4];
   int total    = 0;
   int bad      = 0;
   int cnt      = 0;
   int last_fo  = -1;
   int lr_count = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, cnt);
      end
   endtask

   task automatic set_lane(input int i, input logic [DW-1:0] d, input logic v);
      case (i)
         0: begin bus.data_0 = d; bus.valid_0 = v; end
         1: begin bus.data_1 = d; bus.valid_1 = v; end
         2: begin bus.data_2 = d; bus.valid_2 = v; end
         default: begin bus.data_3 = d; bus.valid_3 = v; end
      endcase
   endtask

   // One clk_4f cycle: drive lanes, predict, advance, compare.
   task automatic step(input bit garbage);
      bit           sample;
      logic [W-1:0] e;
      sample = ((cnt + 1) % 4 == 0);
      for (int i = 0; i < 4; i++) begin
         if (sample || !garbage) set_lane(i, lane_d[i], lane_v[i]);
         else set_lane(i, DW'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      end
      chk("load_req", {31'd0, bus.load_req}, {31'd0, sample});
      if (bus.load_req) lr_count++;
      if (sample)
         for (int i = 0; i < 4; i++) exp_q.push_back({lane_v[i], lane_v[i] ? lane_d[i] : IDLE});
      @(posedge clk_4f);
      #1;
      cnt++;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : {1'b0, IDLE};
      chk("data_000", {24'd0, bus.data_000}, {24'd0, e[DW-1:0]});
      chk("valid_000", {31'd0, bus.valid_000}, {31'd0, e[DW]});
      chk("frame_out", {31'd0, bus.frame_out}, {31'd0, sample});
      if (bus.frame_out) begin
         if (last_fo >= 0) chk("frame_period", cnt - last_fo, 4);
         last_fo = cnt;
      end
   endtask

   // Asserts reset between edges, checks the immediate idle state, releases after one edge.
   task automatic do_reset();
      reset_L = 1'b0;
      #1;
      chk("rst_data_000", {24'd0, bus.data_000}, {24'd0, IDLE});
      chk("rst_valid_000", {31'd0, bus.valid_000}, 32'd0);
      chk("rst_frame_out", {31'd0, bus.frame_out}, 32'd0);
      chk("rst_load_req", {31'd0, bus.load_req}, 32'd0);
      exp_q.delete();
      cnt     = 0;
      last_fo = -1;
      @(posedge clk_4f);
      #1;
      reset_L = 1'b1;
   endtask

   task automatic set_frame(input logic [DW-1:0] base, input logic [3:0] v);
      for (int i = 0; i < 4; i++) begin
         lane_d[i] = base + DW'(i);
         lane_v[i] = v[i];
      end
   endtask

   initial begin
      set_frame(8'h00, 4'b0000);
      for (int i = 0; i < 4; i++) set_lane(i, 8'h00, 1'b0);
      #2;
      do_reset();

      // Constant valid frame 11,22,33,44.
      for (int i = 0; i < 4; i++) begin
         lane_d[i] = DW'((i + 1) * 8'h11);
         lane_v[i] = 1'b1;
      end
      repeat (12) step(1'b0);

      // Lane 2 invalid with a recognizable byte that must never surface.
      lane_d[2] = 8'hAA;
      lane_v[2] = 1'b0;
      repeat (8) begin
         step(1'b0);
         chk("no_aa", {31'd0, bus.data_000 == 8'hAA}, 32'd0);
      end

      // Changing frames, lanes only meaningful across the sample edge.
      set_frame(8'h01, 4'b1111);
      repeat (4) step(1'b1);
      set_frame(8'h05, 4'b1111);
      repeat (4) step(1'b1);
      set_frame(8'h09, 4'b1111);
      lr_count = 0;
      repeat (16) step(1'b1);
      chk("load_req_count", lr_count, 4);

      // Reset while lane 2 is on the output.
      repeat (2) step(1'b1);
      do_reset();
      set_frame(8'h41, 4'b1011);
      repeat (8) step(1'b1);

      // Long random run.
      repeat (100) begin
         set_frame(DW'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));
         for (int i = 0; i < 4; i++) lane_d[i] = DW'($urandom_range(0, 255));
         repeat (4) step(1'b1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
